// File: rtl/axis_io.sv
// AXI-Stream style channel bundle carrying one raw sample word per beat.
// Latency: none; this is only a wiring bundle.
// Backpressure: the Source holds tvalid/tdata until the Sink raises tready.
interface axis_io #(
  parameter int DATA_WIDTH = 16
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport Source (output tdata, output tvalid, input tready);
  modport Sink   (input tdata, input tvalid, output tready);
endinterface

// File: rtl/xadc_drp_scheduler.sv
// XADC DRP scheduler: reads voltage then current per end-of-sequence and interleaves host cfg accesses.
// Latency: eos edge -> voltage den next cycle; drdy edge -> next den / push / ack next cycle.
// Backpressure: a sample arriving at a stalled channel overwrites it and bumps a saturating drop count.
module xadc_drp_scheduler #(
  parameter logic [6:0] VOLTAGE_ADDR = 7'h1C,
  parameter logic [6:0] CURRENT_ADDR = 7'h14,
  parameter int         DRP_TIMEOUT  = 63
) (
  input  logic        xadc_dclk,
  input  logic        xadc_reset,
  input  logic        xadc_eos,
  output logic [6:0]  xadc_daddr,
  output logic        xadc_den,
  output logic        xadc_dwe,
  output logic [15:0] xadc_di,
  input  logic        xadc_drdy,
  input  logic [15:0] xadc_do,
  input  logic        cfg_req,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_ack,
  output logic [15:0] cfg_rdata,
  axis_io.Source      voltage_channel,
  axis_io.Source      current_monitor_channel,
  output logic [7:0]  drop_count,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE, RD_V_ISSUE, RD_V_WAIT, RD_I_ISSUE, RD_I_WAIT, CFG_ISSUE, CFG_WAIT
  } state_t;

  localparam int          CW      = $clog2(DRP_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(DRP_TIMEOUT - 1);

  state_t        state_q;
  logic [6:0]    daddr_q;
  logic          den_q, dwe_q, cfg_ack_q, cfg_wr_q;
  logic [15:0]   di_q, cfg_rdata_q;
  logic          eos_pending_q, last_was_seq_q, timeout_err_q;
  logic [CW-1:0] wait_cnt_q;
  logic [15:0]   v_tdata_q, i_tdata_q;
  logic          v_tvalid_q, i_tvalid_q;
  logic [7:0]    drop_q;

  logic in_wait, wait_hit, wait_to, wait_exit, eos_seen, cfg_live, push_v, push_i, drop_hit;

  // drdy only counts inside a WAIT state; the wait spans exactly DRP_TIMEOUT cycles before giving up
  assign in_wait   = (state_q == RD_V_WAIT) || (state_q == RD_I_WAIT) || (state_q == CFG_WAIT);
  assign wait_hit  = in_wait && xadc_drdy;
  assign wait_to   = in_wait && !xadc_drdy && (wait_cnt_q == TO_LAST);
  assign wait_exit = wait_hit || wait_to;
  // An eos on this very edge counts as pending so the voltage den follows it by one cycle
  assign eos_seen  = eos_pending_q || xadc_eos;
  // The host still holds cfg_req during the ack cycle; that request is already served
  assign cfg_live  = cfg_req && !cfg_ack_q;
  assign push_v    = (state_q == RD_V_WAIT) && xadc_drdy;
  assign push_i    = (state_q == RD_I_WAIT) && xadc_drdy;
  assign drop_hit  = (push_v && v_tvalid_q && !voltage_channel.tready) ||
                     (push_i && i_tvalid_q && !current_monitor_channel.tready);

  // Scheduler FSM with registered DRP strobes, cfg handshake, eos bookkeeping and wait timer
  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) begin
      state_q        <= IDLE;
      daddr_q        <= '0;
      den_q          <= 1'b0;
      dwe_q          <= 1'b0;
      di_q           <= '0;
      cfg_ack_q      <= 1'b0;
      cfg_wr_q       <= 1'b0;
      cfg_rdata_q    <= '0;
      eos_pending_q  <= 1'b0;
      last_was_seq_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      wait_cnt_q     <= '0;
    end else begin
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      daddr_q   <= '0;
      cfg_ack_q <= 1'b0;
      if (xadc_eos) eos_pending_q <= 1'b1;
      if (in_wait) wait_cnt_q <= wait_exit ? '0 : wait_cnt_q + 1'b1;
      if (wait_to) timeout_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (eos_seen && !(cfg_live && last_was_seq_q)) begin
            state_q <= RD_V_ISSUE;
            den_q   <= 1'b1;
            daddr_q <= VOLTAGE_ADDR;
          end else if (cfg_live) begin
            state_q  <= CFG_ISSUE;
            den_q    <= 1'b1;
            daddr_q  <= cfg_addr;
            dwe_q    <= cfg_we;
            di_q     <= cfg_wdata;
            cfg_wr_q <= cfg_we;
          end
        end
        RD_V_ISSUE: begin
          state_q <= RD_V_WAIT;
          if (!xadc_eos) eos_pending_q <= 1'b0;
        end
        RD_V_WAIT: begin
          if (wait_exit) begin
            state_q <= RD_I_ISSUE;
            den_q   <= 1'b1;
            daddr_q <= CURRENT_ADDR;
          end
        end
        RD_I_ISSUE: state_q <= RD_I_WAIT;
        RD_I_WAIT: begin
          if (wait_exit) begin
            state_q        <= IDLE;
            last_was_seq_q <= 1'b1;
          end
        end
        CFG_ISSUE: state_q <= CFG_WAIT;
        CFG_WAIT: begin
          if (wait_exit) begin
            state_q        <= IDLE;
            last_was_seq_q <= 1'b0;
            cfg_ack_q      <= 1'b1;
            if (wait_to)        cfg_rdata_q <= 16'hFFFF;
            else if (!cfg_wr_q) cfg_rdata_q <= xadc_do;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Single-entry output registers per channel; a push into a stalled entry overwrites and is counted
  always_ff @(posedge xadc_dclk or posedge xadc_reset) begin
    if (xadc_reset) begin
      v_tdata_q  <= '0;
      v_tvalid_q <= 1'b0;
      i_tdata_q  <= '0;
      i_tvalid_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push_v) begin
        v_tdata_q  <= xadc_do;
        v_tvalid_q <= 1'b1;
      end else if (v_tvalid_q && voltage_channel.tready) begin
        v_tvalid_q <= 1'b0;
      end
      if (push_i) begin
        i_tdata_q  <= xadc_do;
        i_tvalid_q <= 1'b1;
      end else if (i_tvalid_q && current_monitor_channel.tready) begin
        i_tvalid_q <= 1'b0;
      end
      if (drop_hit && (drop_q != 8'hFF)) drop_q <= drop_q + 1'b1;
    end
  end

  assign xadc_daddr                     = daddr_q;
  assign xadc_den                       = den_q;
  assign xadc_dwe                       = dwe_q;
  assign xadc_di                        = di_q;
  assign cfg_ack                        = cfg_ack_q;
  assign cfg_rdata                      = cfg_rdata_q;
  assign voltage_channel.tdata          = v_tdata_q;
  assign voltage_channel.tvalid         = v_tvalid_q;
  assign current_monitor_channel.tdata  = i_tdata_q;
  assign current_monitor_channel.tvalid = i_tvalid_q;
  assign drop_count                     = drop_q;
  assign timeout_err                    = timeout_err_q;

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Directed bench for xadc_drp_scheduler with a small DRP slave model.
// The slave answers den after a fixed latency; a monitor logs den strobes, acks and stream beats.
module tb_xadc_drp_scheduler;
  localparam int BFM_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, eos, cfg_req, cfg_we;
  logic [6:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  wire  [6:0]  daddr;
  wire         den, dwe;
  wire  [15:0] di;
  wire         drdy;
  wire  [15:0] dout;
  wire         cfg_ack, timeout_err;
  wire  [15:0] cfg_rdata;
  wire  [7:0]  drop_count;

  logic        bfm_drdy, man_drdy, bfm_en;
  logic [15:0] bfm_do, man_do, v_sample, i_sample;
  assign drdy = bfm_drdy | man_drdy;
  assign dout = bfm_drdy ? bfm_do : man_do;

  axis_io #(.DATA_WIDTH(16)) v_if ();
  axis_io #(.DATA_WIDTH(16)) i_if ();

  xadc_drp_scheduler dut (
    .xadc_dclk(clk), .xadc_reset(rst), .xadc_eos(eos),
    .xadc_daddr(daddr), .xadc_den(den), .xadc_dwe(dwe), .xadc_di(di),
    .xadc_drdy(drdy), .xadc_do(dout),
    .cfg_req(cfg_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata),
    .voltage_channel(v_if), .current_monitor_channel(i_if),
    .drop_count(drop_count), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // monitor-owned logs
  int          cyc = 0;
  int          ack_cnt = 0;
  logic [6:0]  den_addr_q[$];
  int          den_cyc_q[$];
  logic        den_we_q[$];
  logic [15:0] den_di_q[$];
  logic [15:0] vq[$];
  logic [15:0] iq[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    int k = 0;
    while (cfg_ack !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
  endtask

  // DRP slave: answers each den with one drdy pulse BFM_LAT cycles later
  initial begin
    logic [15:0] mem [0:127];
    logic [6:0]  b_addr;
    logic        b_we, busy;
    logic [15:0] b_di;
    int          cnt;
    for (int a = 0; a < 128; a++) mem[a] = 16'h0000;
    mem[7'h40] = 16'hBEEF;
    bfm_drdy = 1'b0; bfm_do = '0; busy = 1'b0; cnt = 0;
    b_addr = '0; b_we = 1'b0; b_di = '0;
    forever begin
      @(negedge clk);
      bfm_drdy = 1'b0;
      bfm_do   = '0;
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (busy) begin
          cnt--;
          if (cnt == 0) begin
            busy     = 1'b0;
            bfm_drdy = 1'b1;
            if (b_we)                mem[b_addr] = b_di;
            else if (b_addr == 7'h1C) bfm_do = v_sample;
            else if (b_addr == 7'h14) bfm_do = i_sample;
            else                      bfm_do = mem[b_addr];
          end
        end
        if (den && bfm_en) begin
          busy = 1'b1; cnt = BFM_LAT; b_addr = daddr; b_we = dwe; b_di = di;
        end
      end
    end
  end

  // Monitor: samples mid-low-phase, after all bench drives of that negedge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (den) begin
        den_addr_q.push_back(daddr);
        den_cyc_q.push_back(cyc);
        den_we_q.push_back(dwe);
        den_di_q.push_back(di);
      end
      if (cfg_ack) ack_cnt++;
      if (v_if.tvalid && v_if.tready) vq.push_back(v_if.tdata);
      if (i_if.tvalid && i_if.tready) iq.push_back(i_if.tdata);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bd, bv, bi, ba, k;
    logic [15:0] vtab [3];
    vtab[0] = 16'h1111; vtab[1] = 16'h2222; vtab[2] = 16'h3333;
    rst = 1'b1; eos = 1'b0; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    man_drdy = 1'b0; man_do = '0; bfm_en = 1'b1; v_sample = '0; i_sample = '0;
    v_if.tready = 1'b1; i_if.tready = 1'b1;
    tick(3);

    // reset state
    check("rst_den",      32'(den), 32'd0);
    check("rst_daddr",    32'(daddr), 32'd0);
    check("rst_ack",      32'(cfg_ack), 32'd0);
    check("rst_rdata",    32'(cfg_rdata), 32'd0);
    check("rst_v_tvalid", 32'(v_if.tvalid), 32'd0);
    check("rst_i_tdata",  32'(i_if.tdata), 32'd0);
    check("rst_drop",     32'(drop_count), 32'd0);
    check("rst_timeout",  32'(timeout_err), 32'd0);
    rst = 1'b0;
    tick(2);

    // single eos, both channels ready
    v_sample = 16'h8A3C; i_sample = 16'h4F10;
    bd = den_addr_q.size(); bv = vq.size(); bi = iq.size();
    eos = 1'b1; tick(1);
    check("t1_den_lat",   32'(den), 32'd1);
    check("t1_den_addr",  32'(daddr), 32'h1C);
    eos = 1'b0;
    k = 0;
    while (iq.size() == bi && k < 100) begin tick(1); k++; end
    tick(2);
    check("t1_v_beats",   32'(vq.size() - bv), 32'd1);
    check("t1_v_data",    32'(vq[bv]), 32'h8A3C);
    check("t1_i_beats",   32'(iq.size() - bi), 32'd1);
    check("t1_i_data",    32'(iq[bi]), 32'h4F10);
    check("t1_den_count", 32'(den_addr_q.size() - bd), 32'd2);
    check("t1_den2_addr", 32'(den_addr_q[bd+1]), 32'h14);
    check("t1_den_gap",   32'(den_cyc_q[bd+1] - den_cyc_q[bd]), 32'd4);
    check("t1_drop",      32'(drop_count), 32'd0);
    check("t1_v_tvalid",  32'(v_if.tvalid), 32'd0);

    // stalled voltage channel, three eos
    v_if.tready = 1'b0;
    bv = vq.size(); bi = iq.size();
    for (int s = 0; s < 3; s++) begin
      v_sample = vtab[s];
      eos = 1'b1; tick(1); eos = 1'b0;
      tick(14);
    end
    check("t2_v_no_beat", 32'(vq.size() - bv), 32'd0);
    check("t2_v_tvalid",  32'(v_if.tvalid), 32'd1);
    check("t2_v_tdata",   32'(v_if.tdata), 32'h3333);
    check("t2_drop",      32'(drop_count), 32'd2);
    check("t2_i_beats",   32'(iq.size() - bi), 32'd3);
    v_if.tready = 1'b1;
    tick(2);
    check("t2_v_release", 32'(vq.size() - bv), 32'd1);
    check("t2_v_last",    32'(vq[bv]), 32'h3333);
    check("t2_v_cleared", 32'(v_if.tvalid), 32'd0);
    check("t2_drop_hold", 32'(drop_count), 32'd2);

    // cfg read racing eos: sequence first, then cfg ahead of the next pending sequence
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    check("t3_drop_rst",  32'(drop_count), 32'd0);
    bd = den_addr_q.size(); ba = ack_cnt;
    cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 7'h40;
    eos = 1'b1; tick(1); eos = 1'b0;
    check("t3_seq_first", 32'(daddr), 32'h1C);
    tick(2);
    eos = 1'b1; tick(1); eos = 1'b0;
    wait_ack();
    check("t3_ack",       32'(cfg_ack), 32'd1);
    check("t3_rdata",     32'(cfg_rdata), 32'hBEEF);
    cfg_req = 1'b0;
    tick(1);
    check("t3_ack_pulse", 32'(cfg_ack), 32'd0);
    tick(20);
    check("t3_ack_count", 32'(ack_cnt - ba), 32'd1);
    check("t3_den_count", 32'(den_addr_q.size() - bd), 32'd5);
    check("t3_order1",    32'(den_addr_q[bd+1]), 32'h14);
    check("t3_order2",    32'(den_addr_q[bd+2]), 32'h40);
    check("t3_order3",    32'(den_addr_q[bd+3]), 32'h1C);
    check("t3_order4",    32'(den_addr_q[bd+4]), 32'h14);

    // cfg write keeps rdata, then read back what was written
    bd = den_addr_q.size();
    cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 7'h41; cfg_wdata = 16'h1357;
    wait_ack();
    check("wr_ack",       32'(cfg_ack), 32'd1);
    check("wr_rdata_hold",32'(cfg_rdata), 32'hBEEF);
    cfg_req = 1'b0; cfg_we = 1'b0;
    tick(2);
    check("wr_den_addr",  32'(den_addr_q[bd]), 32'h41);
    check("wr_dwe",       32'(den_we_q[bd]), 32'd1);
    check("wr_di",        32'(den_di_q[bd]), 32'h1357);
    cfg_req = 1'b1;
    wait_ack();
    check("rd_back",      32'(cfg_rdata), 32'h1357);
    cfg_req = 1'b0;
    tick(2);

    // silent DRP slave: both reads time out
    bfm_en = 1'b0;
    bd = den_addr_q.size(); bv = vq.size(); bi = iq.size();
    eos = 1'b1; tick(1); eos = 1'b0;
    check("t4_to_clear",  32'(timeout_err), 32'd0);
    tick(150);
    check("t4_timeout",   32'(timeout_err), 32'd1);
    check("t4_v_none",    32'(vq.size() - bv), 32'd0);
    check("t4_i_none",    32'(iq.size() - bi), 32'd0);
    check("t4_den_count", 32'(den_addr_q.size() - bd), 32'd2);
    check("t4_i_issued",  32'(den_addr_q[bd+1]), 32'h14);
    check("t4_den_gap",   32'(den_cyc_q[bd+1] - den_cyc_q[bd]), 32'd64);

    // reset during the current-read wait, late drdy afterwards
    bd = den_addr_q.size(); bi = iq.size();
    eos = 1'b1; tick(1); eos = 1'b0;
    k = 0;
    while (den_addr_q.size() < bd + 2 && k < 150) begin tick(1); k++; end
    tick(2);
    rst = 1'b1; tick(2); rst = 1'b0;
    tick(2);
    man_drdy = 1'b1; man_do = 16'hDEAD;
    tick(1);
    man_drdy = 1'b0;
    tick(3);
    check("t5_i_none",    32'(iq.size() - bi), 32'd0);
    check("t5_i_tvalid",  32'(i_if.tvalid), 32'd0);
    check("t5_i_tdata",   32'(i_if.tdata), 32'd0);
    check("t5_den",       32'(den), 32'd0);
    check("t5_daddr",     32'(daddr), 32'd0);
    check("t5_timeout",   32'(timeout_err), 32'd0);
    check("t5_ack",       32'(cfg_ack), 32'd0);
    check("t5_rdata",     32'(cfg_rdata), 32'd0);
    check("t5_no_den",    32'(den_addr_q.size() - bd), 32'd2);
    bfm_en = 1'b1;
    bi = iq.size();
    eos = 1'b1; tick(1); eos = 1'b0;
    check("t5_idle_den",  32'(daddr), 32'h1C);
    tick(20);
    check("t5_i_beat",    32'(iq.size() - bi), 32'd1);
    check("t5_i_data",    32'(iq[bi]), 32'h4F10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
